// File: rtl/lpc_periph_multiwin.sv
// LPC I/O-cycle peripheral with base/mask decode windows, req/ack back end (SYNC long-wait and
// timeout error) and a capture FIFO of completed cycles. Define LPC_PERIPH_TPM_EN to accept START 0x5.
module lpc_periph_multiwin #(
  parameter int unsigned           NUM_WIN    = 2,
  parameter logic [16*NUM_WIN-1:0] WIN_BASE   = {16'h0080, 16'h002E},
  parameter logic [16*NUM_WIN-1:0] WIN_MASK   = {16'hFFFF, 16'hFFFE},
  parameter int unsigned           WAIT_MAX   = 8,
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        lframe_i,
  input  logic [3:0]  lad_i,
  output logic [3:0]  lad_o,
  output logic        lad_oe_o,
  output logic        req_valid_o,
  output logic        req_we_o,
  output logic [15:0] req_addr_o,
  output logic [7:0]  req_wdata_o,
  output logic [2:0]  req_win_o,
  input  logic        req_ready_i,
  input  logic [7:0]  rsp_rdata_i,
  output logic [31:0] cap_data_o,
  output logic        cap_valid_o,
  input  logic        cap_ready_i,
  output logic        cap_ovf_o
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  WaitMax = 8'(WAIT_MAX);
`ifdef LPC_PERIPH_TPM_EN
  localparam logic TpmEn = 1'b1;
`else
  localparam logic TpmEn = 1'b0;
`endif

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StStart  = 4'd1;
  localparam logic [3:0] StAddr1  = 4'd2;
  localparam logic [3:0] StAddr2  = 4'd3;
  localparam logic [3:0] StAddr3  = 4'd4;
  localparam logic [3:0] StAddr4  = 4'd5;
  localparam logic [3:0] StData1  = 4'd6;
  localparam logic [3:0] StData2  = 4'd7;
  localparam logic [3:0] StTar1   = 4'd8;
  localparam logic [3:0] StTar2   = 4'd9;
  localparam logic [3:0] StSync   = 4'd10;
  localparam logic [3:0] StRdata1 = 4'd11;
  localparam logic [3:0] StRdata2 = 4'd12;
  localparam logic [3:0] StFtar1  = 4'd13;
  localparam logic [3:0] StFtar2  = 4'd14;

  logic [3:0]  state_q, state_d;
  logic        start_ok_q, start_ok_d, tpm_q, tpm_d, we_q, we_d;
  logic [15:0] addr_q, addr_d, full_addr;
  logic [7:0]  data_q, data_d, wait_q, wait_d;
  logic [2:0]  win_q, win_d, hit_win;
  logic        req_valid_q, req_valid_d, ack_q, ack_d, err_q, err_d;
  logic        hit, accept, tar_go, push;

  assign accept    = req_valid_q & req_ready_i;
  // The last address nibble is still on the bus when the decision to enter TAR1 is made.
  assign full_addr = (state_q == StAddr4) ? {addr_q[11:0], lad_i} : addr_q;

  always_comb begin
    hit     = 1'b0;
    hit_win = 3'd0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      if (!hit && ((full_addr & WIN_MASK[16*i +: 16]) ==
                   (WIN_BASE[16*i +: 16] & WIN_MASK[16*i +: 16]))) begin
        hit     = 1'b1;
        hit_win = 3'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    start_ok_d  = start_ok_q;
    tpm_d       = tpm_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wait_d      = wait_q;
    win_d       = win_q;
    req_valid_d = req_valid_q;
    ack_d       = ack_q;
    err_d       = err_q;
    tar_go      = 1'b0;
    case (state_q)
      StStart: begin
        state_d = StIdle;
        if (start_ok_q && lad_i[3:2] == 2'b00) begin
          we_d    = lad_i[1];
          state_d = StAddr1;
        end
      end
      StAddr1: begin addr_d = {addr_q[11:0], lad_i}; state_d = StAddr2; end
      StAddr2: begin addr_d = {addr_q[11:0], lad_i}; state_d = StAddr3; end
      StAddr3: begin addr_d = {addr_q[11:0], lad_i}; state_d = StAddr4; end
      StAddr4: begin
        addr_d = full_addr;
        if (we_q) state_d = StData1;
        else      tar_go  = 1'b1;
      end
      StData1: begin data_d = {data_q[7:4], lad_i}; state_d = StData2; end
      StData2: begin data_d = {lad_i, data_q[3:0]}; tar_go = 1'b1; end
      StTar1:  state_d = StTar2;
      StTar2:  begin state_d = StSync; wait_d = 8'd0; end
      StSync: begin
        if (ack_q || accept) begin
          state_d = we_q ? StFtar1 : StRdata1;
        end else if (wait_q == WaitMax) begin
          err_d       = 1'b1;
          req_valid_d = 1'b0;
          if (!we_q) data_d = 8'hFF;
          state_d     = we_q ? StFtar1 : StRdata1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StRdata1: state_d = StRdata2;
      StRdata2: state_d = StFtar1;
      StFtar1:  state_d = StFtar2;
      StFtar2:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (tar_go) begin
      if (hit) begin
        state_d     = StTar1;
        req_valid_d = 1'b1;
        win_d       = hit_win;
        ack_d       = 1'b0;
        err_d       = 1'b0;
      end else begin
        state_d = StIdle;
      end
    end

    if (accept) begin
      req_valid_d = 1'b0;
      ack_d       = 1'b1;
      if (!we_q) data_d = rsp_rdata_i;
    end

    // LFRAME# low overrides everything: abort and restart START decoding.
    if (!lframe_i) begin
      state_d     = StStart;
      start_ok_d  = (lad_i == 4'h0) || (TpmEn && lad_i == 4'h5);
      tpm_d       = TpmEn && (lad_i == 4'h5);
      req_valid_d = 1'b0;
      ack_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q     <= StIdle;
      start_ok_q  <= 1'b0;
      tpm_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 16'h0;
      data_q      <= 8'h0;
      wait_q      <= 8'h0;
      win_q       <= 3'd0;
      req_valid_q <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_ok_q  <= start_ok_d;
      tpm_q       <= tpm_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wait_q      <= wait_d;
      win_q       <= win_d;
      req_valid_q <= req_valid_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    lad_o    = 4'h0;
    lad_oe_o = 1'b0;
    case (state_q)
      StSync: begin
        lad_oe_o = 1'b1;
        if (ack_q || accept)       lad_o = 4'h0;
        else if (wait_q == WaitMax) lad_o = 4'hA;
        else                        lad_o = 4'h6;
      end
      StRdata1: begin lad_oe_o = 1'b1; lad_o = data_q[3:0]; end
      StRdata2: begin lad_oe_o = 1'b1; lad_o = data_q[7:4]; end
      StFtar1:  begin lad_oe_o = 1'b1; lad_o = 4'hF; end
      default:  ;
    endcase
  end

  assign req_valid_o = req_valid_q;
  assign req_we_o    = we_q;
  assign req_addr_o  = addr_q;
  assign req_wdata_o = data_q;
  assign req_win_o   = win_q;

  // Capture FIFO; next-state data/err are used so a write that errors in SYNC logs err=1.
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        ovf_q, empty, full, pop, do_push;
  logic [31:0] cap_in;

  assign push    = (state_d == StFtar1);
  assign cap_in  = {4'h0, addr_q, data_d, err_d, tpm_q, ~we_q, 1'b1};
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = !empty && cap_ready_i;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 32'h0;
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= cap_in;
        wptr_q                <= wptr_q + (AW+1)'(1);
      end
      if (pop) rptr_q <= rptr_q + (AW+1)'(1);
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign cap_valid_o = !empty;
  assign cap_data_o  = empty ? 32'h0 : mem_q[rptr_q[AW-1:0]];
  assign cap_ovf_o   = ovf_q;

endmodule
